hall_commutator: RTL and testbench
==================================

// Module: hall_commutator
// PURPOSE
// - BLDC six-step commutation decoder for the robot motor FPGA path.
// - Takes the 3 raw Hall-sensor lines and a direction bit; produces per-phase drive-high (u) and float (z) controls for the gate drivers.
// - Sits between the Hall input pins and the phase-driver/PWM gating logic. Inputs are synchronised and debounced here; outputs are registered.
// PARAMETERS
// - SYNC_STAGES  2   flops in each input synchroniser chain (h and dir); minimum 2
// - FILTER_LEN   4   consecutive stable cycles needed before a new hall code is accepted; minimum 1
// - DEADTIME     16  all-phases-float cycles inserted on an accepted direction change; 0 = no dead time
// PORTS
// - clk    in   1  system clock; single clock domain
// - rst    in   1  reset, synchronous, active-high
// - h      in   3  raw hall lines, asynchronous; h[0]=A, h[1]=B, h[2]=C
// - dir    in   1  asynchronous; 1 = forward, 0 = reverse
// - u      out  3  per phase (bit0=A, bit1=B, bit2=C): 1 = drive high
// - z      out  3  per phase: 1 = float (high-Z)
// - fault  out  1  present only when HALL_FAULT_EN is defined
// BEHAVIOUR
// - Phase encoding: u=1,z=0 drives high; u=0,z=0 drives low; u=0,z=1 floats. u=1,z=1 never occurs.
// - Reset: u=000, z=111 (all float); accepted code=000; dead-time counter=0; fault=0. Reset mid-operation returns to this state on the next edge.
// - Input path: h and dir each pass through SYNC_STAGES flops. The debouncer holds a candidate code and a counter.
//   - A synchronised h value that differs from the candidate reloads the candidate and clears the count.
//   - After FILTER_LEN consecutive equal cycles, the candidate becomes the accepted code.
//   - Synchronised dir is debounced the same way.
// - Latency: output flop after the decode. An h step is reflected on u/z after SYNC_STAGES+FILTER_LEN+1 edges (7 with defaults).
// - Forward (dir=1) commutation, h -> u/z:
//   - 101 -> 001/100; 100 -> 001/010; 110 -> 010/001
//   - 010 -> 010/100; 011 -> 100/010; 001 -> 100/001
// - Reverse (dir=0): high and low sides swapped, float phase unchanged:
//   - 101 -> 010/100; 100 -> 100/010; 110 -> 100/001
//   - 010 -> 001/100; 011 -> 001/010; 001 -> 010/001
// - Invalid codes 000 and 111: u=000, z=111. Normal decode resumes as soon as a valid code is accepted.
// - Direction change: when the accepted dir toggles, force u=000/z=111 for DEADTIME cycles, then decode with the new dir.
//   - A dir toggle during the dead time restarts the count.
//   - Hall code changes during the dead time are still tracked, but the outputs stay floated.
// - Simultaneous h and dir acceptance: dead time takes priority; the new code is used after it ends.
// CONFIGURATION
// - HALL_FAULT_EN defined:
//   - Adds the fault port. fault goes sticky-high on an accepted invalid code, or on an accepted transition that is not one step forward or back in the 6-step sequence 101,100,110,010,011,001.
//   - The first valid code after reset is exempt from the transition check.
//   - While fault=1: u=000, z=111. Only rst clears fault.
// - HALL_FAULT_EN undefined: no fault port; invalid codes float the phases only while present; jumps are decoded normally.
// STRUCTURE
// - Package hall_pkg:
//   - phase_drive_t struct {u[2:0], z[2:0]}
//   - constants HALL_SEQ[0:5], DRIVE_FLOAT (u=000, z=111)
//   - function commutate(code, dir) returning phase_drive_t
//   - function hall_step(prev, next) returning +1, -1 or illegal
// - Sub-module hall_input_filter: synchroniser plus debounce, parameterised by width (3 for h, 1 for dir). Instantiated twice.
// - Top level: dead-time counter, decode, output register and optional fault logic.
// TESTING
// - Reset: assert rst for 3 cycles with h=101, dir=1 -> u=000, z=111 during reset and for 6 edges after release.
// - Forward sweep: dir=1; step h 101,100,110,010,011,001, holding each 1000 cycles.
//   - Expect u/z = 001/100, 001/010, 010/001, 010/100, 100/010, 100/001.
//   - Each change appears exactly 7 edges after the h change.
// - Glitch: h=101 stable, pulse h=100 for 3 cycles -> u/z unchanged (001/100).
// - Reverse plus dead time: h=110, dir toggles 1->0 -> 16 cycles of u=000/z=111, then u=100, z=001.
// - Invalid codes: h=000 then h=111 -> u=000, z=111. Return to h=011 with dir=1 -> u=100, z=010.
// - HALL_FAULT_EN: valid sequence, then jump 101->110 -> fault=1 and outputs float; rst -> fault=0.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared types, the six-step Hall sequence and the commutation/step helpers
// used by the hall_commutator decoder.
package hall_pkg;

  typedef struct packed {
    logic [2:0] u;
    logic [2:0] z;
  } phase_drive_t;

  typedef enum logic [1:0] {
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } hall_step_t;

  localparam logic [2:0] HALL_SEQ [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  localparam phase_drive_t DRIVE_FLOAT = '{u: 3'b000, z: 3'b111};

  // Position of a code in the six-step sequence, -1 for 000/111.
  function automatic int seq_index(input logic [2:0] code);
    int idx;
    idx = -1;
    for (int i = 0; i < 6; i++)
      if (HALL_SEQ[i] == code) idx = i;
    return idx;
  endfunction

  function automatic phase_drive_t commutate(input logic [2:0] code, input logic dir);
    phase_drive_t drv;
    case (code)
      3'b101:  drv = '{u: 3'b001, z: 3'b100};
      3'b100:  drv = '{u: 3'b001, z: 3'b010};
      3'b110:  drv = '{u: 3'b010, z: 3'b001};
      3'b010:  drv = '{u: 3'b010, z: 3'b100};
      3'b011:  drv = '{u: 3'b100, z: 3'b010};
      3'b001:  drv = '{u: 3'b100, z: 3'b001};
      default: drv = DRIVE_FLOAT;
    endcase
    // Reverse: the low-side phase becomes the high side; all-float maps onto itself.
    if (!dir) drv.u = ~(drv.u | drv.z);
    return drv;
  endfunction

  function automatic hall_step_t hall_step(input logic [2:0] prev, input logic [2:0] next);
    int ip;
    int in;
    hall_step_t st;
    ip = seq_index(prev);
    in = seq_index(next);
    st = STEP_ILLEGAL;
    if (ip >= 0 && in >= 0) begin
      if (in == (ip + 1) % 6)      st = STEP_FWD;
      else if (ip == (in + 1) % 6) st = STEP_REV;
    end
    return st;
  endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Synchroniser chain followed by a debouncer: a value is accepted once the
// synchronised input has held it for FILTER_LEN consecutive cycles.
module hall_input_filter #(
  parameter int             W           = 3,
  parameter int             SYNC_STAGES = 2,
  parameter int             FILTER_LEN  = 4,
  parameter logic [W-1:0]   RESET_VAL   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync;
  logic [W-1:0]                  cand;
  logic [CW-1:0]                 cnt;
  logic [CW-1:0]                 cnt_next;
  logic [W-1:0]                  s;

  assign s = sync[SYNC_STAGES-1];

  // The count includes the cycle the candidate was loaded, so a one-cycle
  // filter accepts on the reload edge.
  always_comb begin
    cnt_next = cnt;
    if (s != cand)                    cnt_next = CW'(1);
    else if (cnt < CW'(FILTER_LEN))   cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      cand <= RESET_VAL;
      cnt  <= '0;
      q    <= RESET_VAL;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      cand <= s;
      cnt  <= cnt_next;
      if (cnt_next == CW'(FILTER_LEN)) q <= s;
    end
  end

endmodule

// File: rtl/hall_commutator.sv
// BLDC six-step commutation decoder: filtered Hall code + direction -> registered
// per-phase drive. Optional sticky sequence fault when HALL_FAULT_EN is defined.
module hall_commutator
  import hall_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int DEADTIME    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] h,
  input  logic       dir,
  output logic [2:0] u,
`ifdef HALL_FAULT_EN
  output logic [2:0] z,
  output logic       fault
`else
  output logic [2:0] z
`endif
);

  localparam int             DTW     = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DTW-1:0] DT_LOAD = DTW'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  logic [2:0]     h_acc;
  logic           dir_acc;
  logic           dir_prev;
  logic           toggle;
  logic [DTW-1:0] dt_cnt;
  logic           dead;
  logic           hold_float;
  phase_drive_t   drv;

  hall_input_filter #(.W(3), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
                      .RESET_VAL(3'b000))
    u_h_filt (.clk(clk), .rst(rst), .d(h), .q(h_acc));

  // Direction resets to forward so leaving reset does not open a dead-time window.
  hall_input_filter #(.W(1), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
                      .RESET_VAL(1'b1))
    u_dir_filt (.clk(clk), .rst(rst), .d(dir), .q(dir_acc));

  assign toggle = dir_acc != dir_prev;
  assign dead   = (DEADTIME > 0) && (toggle || dt_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_prev <= 1'b1;
      dt_cnt   <= '0;
    end else begin
      dir_prev <= dir_acc;
      if (toggle)              dt_cnt <= DT_LOAD;
      else if (dt_cnt != '0)   dt_cnt <= dt_cnt - 1'b1;
    end
  end

`ifdef HALL_FAULT_EN
  logic [2:0] h_prev;
  logic       fault_set;

  // Leaving the reset code 000 is exempt from the step check.
  assign fault_set = (h_acc != h_prev) &&
                     (seq_index(h_acc) < 0 ||
                      (seq_index(h_prev) >= 0 && hall_step(h_prev, h_acc) == STEP_ILLEGAL));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_prev <= 3'b000;
      fault  <= 1'b0;
    end else begin
      h_prev <= h_acc;
      if (fault_set) fault <= 1'b1;
    end
  end

  assign hold_float = dead || fault || fault_set;
`else
  assign hold_float = dead;
`endif

  always_ff @(posedge clk) begin
    if (rst)             drv <= DRIVE_FLOAT;
    else if (hold_float) drv <= DRIVE_FLOAT;
    else                 drv <= commutate(h_acc, dir_acc);
  end

  assign u = drv.u;
  assign z = drv.z;

endmodule

// File: tb/tb_hall_commutator.sv
// Scoreboard bench for hall_commutator: a per-edge reference model queues the
// expected outputs, a negedge monitor compares; directed anchors plus random stimulus.
module tb_hall_commutator;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int DEADTIME    = 16;
  localparam int HD          = SYNC_STAGES + FILTER_LEN;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] h;
  logic       dir;
  logic [2:0] u;
  logic [2:0] z;
  logic       fault_w;

  int checks = 0;
  int errors = 0;

  hall_commutator #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .DEADTIME(DEADTIME)) dut (
    .clk(clk), .rst(rst), .h(h), .dir(dir), .u(u),
`ifdef HALL_FAULT_EN
    .z(z), .fault(fault_w)
`else
    .z(z)
`endif
  );

`ifndef HALL_FAULT_EN
  assign fault_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [2:0] seq_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  function automatic int ref_idx(input logic [2:0] c);
    int r;
    r = -1;
    for (int i = 0; i < 6; i++) if (seq_tab[i] == c) r = i;
    return r;
  endfunction

  // Returns {u, z}. Forward table as (high phase, float phase); reverse drives
  // the remaining (low) phase high instead.
  function automatic logic [5:0] ref_drive(input logic [2:0] c, input logic d);
    int hi, fl, lo;
    logic [2:0] uu, zz;
    case (c)
      3'b101:  begin hi = 0; fl = 2; end
      3'b100:  begin hi = 0; fl = 1; end
      3'b110:  begin hi = 1; fl = 0; end
      3'b010:  begin hi = 1; fl = 2; end
      3'b011:  begin hi = 2; fl = 1; end
      3'b001:  begin hi = 2; fl = 0; end
      default: begin hi = -1; fl = -1; end
    endcase
    if (hi < 0) return {3'b000, 3'b111};
    lo = 3 - hi - fl;
    if (!d) hi = lo;
    uu = 3'b000; zz = 3'b000;
    uu[hi] = 1'b1;
    zz[fl] = 1'b1;
    return {uu, zz};
  endfunction

  function automatic bit bad_move(input logic [2:0] a, input logic [2:0] b);
    int ia, ib, df;
    ia = ref_idx(a);
    ib = ref_idx(b);
    if (ib < 0) return 1'b1;
    if (ia < 0) return 1'b0;
    df = (ib - ia + 6) % 6;
    return !(df == 1 || df == 5);
  endfunction

  logic [6:0] exp_q[$];   // {u, z, fault}
  logic [2:0] hh [HD];
  logic       dd [HD];
  int         cyc = 0;
  int         last_dchg;
  logic [2:0] m_acc_h, m_prev_h;
  logic       m_acc_d, m_fault, m_fnew, m_forced, st_h, st_d;
  logic [5:0] m_drv;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        exp_q.push_back({3'b000, 3'b111, 1'b0});
        m_acc_h = 3'b000; m_prev_h = 3'b000; m_acc_d = 1'b1; m_fault = 1'b0;
        last_dchg = -100000;
        for (int j = 0; j < HD; j++) begin hh[j] = 3'b000; dd[j] = 1'b1; end
      end else begin
        m_forced = (cyc - last_dchg >= 1) && (cyc - last_dchg <= DEADTIME);
`ifdef HALL_FAULT_EN
        m_fnew = m_fault || (m_acc_h != m_prev_h && bad_move(m_prev_h, m_acc_h));
`else
        m_fnew = 1'b0;
`endif
        m_drv = (m_forced || m_fnew) ? {3'b000, 3'b111} : ref_drive(m_acc_h, m_acc_d);
        exp_q.push_back({m_drv, m_fnew});
        m_fault  = m_fnew;
        m_prev_h = m_acc_h;
        for (int j = HD - 1; j > 0; j--) begin hh[j] = hh[j-1]; dd[j] = dd[j-1]; end
        hh[0] = h; dd[0] = dir;
        // Accept once the synchronised value has been identical for FILTER_LEN samples.
        st_h = 1'b1; st_d = 1'b1;
        for (int j = SYNC_STAGES; j < HD; j++) begin
          if (hh[j] != hh[SYNC_STAGES]) st_h = 1'b0;
          if (dd[j] != dd[SYNC_STAGES]) st_d = 1'b0;
        end
        if (st_h) m_acc_h = hh[SYNC_STAGES];
        if (st_d && dd[SYNC_STAGES] != m_acc_d) begin
          m_acc_d   = dd[SYNC_STAGES];
          last_dchg = cyc;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [6:0] got, want;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {u, z, fault_w};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard cyc%0d: got u=%b z=%b fault=%b, expected u=%b z=%b fault=%b",
                   cyc, got[6:4], got[3:1], got[0], want[6:4], want[3:1], want[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic anchor(input string name, input logic [2:0] eu, input logic [2:0] ez);
    checks++;
    if ({u, z} !== {eu, ez}) begin
      errors++;
      $display("FAIL %s: got u=%b z=%b, expected u=%b z=%b", name, u, z, eu, ez);
    end
  endtask

  logic [2:0] sw_u [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  logic [2:0] sw_z [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
  int pos;

  initial begin
    rst = 1'b1; h = 3'b101; dir = 1'b1;
    step(3);
    anchor("reset", 3'b000, 3'b111);
    rst = 1'b0;
    step(6);
    anchor("release_edge6", 3'b000, 3'b111);
    step(1);
    anchor("release_edge7", 3'b001, 3'b100);
    step(993);

    for (int i = 1; i < 6; i++) begin
      h = seq_tab[i];
      step(6);
      anchor("sweep_edge6", sw_u[i-1], sw_z[i-1]);
      step(1);
      anchor("sweep_edge7", sw_u[i], sw_z[i]);
      step(993);
    end

    h = 3'b101; step(20);
    h = 3'b100; step(3);
    h = 3'b101; step(20);
    anchor("glitch", 3'b001, 3'b100);

    h = 3'b100; step(20);
    h = 3'b110; step(20);
    anchor("rev_pre", 3'b010, 3'b001);
    dir = 1'b0;
    step(7);
    anchor("deadtime_first", 3'b000, 3'b111);
    step(15);
    anchor("deadtime_last", 3'b000, 3'b111);
    step(1);
    anchor("rev_post", 3'b100, 3'b001);

    dir = 1'b1; step(30);
    h = 3'b000; step(10);
    anchor("invalid_000", 3'b000, 3'b111);
    h = 3'b111; step(10);
    anchor("invalid_111", 3'b000, 3'b111);
`ifdef HALL_FAULT_EN
    checks++;
    if (fault_w !== 1'b1) begin errors++; $display("FAIL fault_set: got %b, expected 1", fault_w); end
    rst = 1'b1; step(2); rst = 1'b0;
    checks++;
    if (fault_w !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b, expected 0", fault_w); end
`endif
    h = 3'b011; step(10);
    anchor("invalid_recover", 3'b100, 3'b010);

    // Random phase: mostly legal steps, some jumps/invalids, direction flips, resets.
    pos = 4;
    repeat (400) begin
      if ($urandom_range(0, 99) < 80) begin
        pos = ($urandom_range(0, 1) != 0) ? (pos + 1) % 6 : (pos + 5) % 6;
        h = seq_tab[pos];
      end else begin
        h = 3'($urandom_range(0, 7));
        if (ref_idx(h) >= 0) pos = ref_idx(h);
      end
      if ($urandom_range(0, 99) < 10) dir = ~dir;
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
      end
      step($urandom_range(1, 12));
    end

    step(40);
    step(2);
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected at most 1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
